// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame deserializer.
package uart_pkg;

  localparam int MAX_WIDTH_DEF = 9;
  localparam int MIN_DATA_LEN  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rx_parity_chk.sv
// Parity checker: XOR of the data bits below len, the received parity bit and the odd/even select.
module uart_rx_parity_chk
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int CNT_W     = 4
) (
  input  logic [MAX_WIDTH-1:0] data,
  input  logic [CNT_W-1:0]     len,
  input  logic                 rx_parity,
  input  logic                 parity_odd,
  output logic                 par_err
);

  function automatic logic masked_xor(input logic [MAX_WIDTH-1:0] d, input logic [CNT_W-1:0] n);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (CNT_W'(i) < n) acc = acc ^ d[i];
      else               acc = acc;
    end
    return acc;
  endfunction

  // Combined parity error over masked data, received bit and polarity
  always_comb par_err = masked_xor(data, len) ^ rx_parity ^ parity_odd;

endmodule

// File: rtl/uart_rx_frame_deserializer.sv
// UART RX frame deserializer: indexed bit assembly, short/aborted frame handling, valid/ready output.
// Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_frame_deserializer
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     data_len,
  input  logic                 msb_first,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 enable,
  input  logic                 sampled_bit,
  input  logic                 success,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [MAX_WIDTH-1:0] out_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXW_C = CNT_W'(MAX_WIDTH);

  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       len_r, count_r, idx_s;
  logic                   msb_r;
  logic [MAX_WIDTH-1:0]   shreg_r, shreg_nxt_s;
  logic                   start_s, bit_wr_s, par_wr_s, commit_s, short_s;
  logic                   cfg_par_en_s, lat_par_en_s, par_err_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state logic; abort outranks success, which outranks enable
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!abort && enable) begin
          if (data_len <= ONE_C) state_nxt_s = cfg_par_en_s ? S_PAR : S_WAIT;
          else                   state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DATA: begin
        if (abort || success)                            state_nxt_s = S_IDLE;
        else if (enable && ((count_r + ONE_C) >= len_r)) state_nxt_s = lat_par_en_s ? S_PAR : S_WAIT;
        else                                             state_nxt_s = S_DATA;
      end
      S_PAR: begin
        if (abort || success) state_nxt_s = S_IDLE;
        else if (enable)      state_nxt_s = S_WAIT;
        else                  state_nxt_s = S_PAR;
      end
      S_WAIT: begin
        if (abort || success) state_nxt_s = S_IDLE;
        else                  state_nxt_s = S_WAIT;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    start_s  = 1'b0;
    bit_wr_s = 1'b0;
    par_wr_s = 1'b0;
    commit_s = 1'b0;
    short_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        start_s  = enable && !abort;
        bit_wr_s = enable && !abort;
      end
      S_DATA: begin
        bit_wr_s = enable && !abort && !success;
        short_s  = success && !abort;
      end
      S_PAR: begin
        par_wr_s = enable && !abort && !success;
        short_s  = success && !abort;
      end
      S_WAIT:  commit_s = success && !abort;
      default: commit_s = 1'b0;
    endcase
  end

  // Bit position: the first bit uses the live configuration, later bits the latched one
  always_comb begin
    if (state_r == S_IDLE) idx_s = msb_first ? (data_len - ONE_C) : {CNT_W{1'b0}};
    else                   idx_s = msb_r ? (len_r - ONE_C - count_r) : count_r;
  end

  // Indexed write into the assembly register
  always_comb begin
    shreg_nxt_s = start_s ? {MAX_WIDTH{1'b0}} : shreg_r;
    if (bit_wr_s && (idx_s < MAXW_C)) shreg_nxt_s[idx_s] = sampled_bit;
    else                              shreg_nxt_s = shreg_nxt_s;
  end

  // Frame configuration latch, bit counter and assembly register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r   <= {CNT_W{1'b0}};
      msb_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
      shreg_r <= {MAX_WIDTH{1'b0}};
    end else begin
      shreg_r <= shreg_nxt_s;
      if (start_s) begin
        len_r   <= data_len;
        msb_r   <= msb_first;
        count_r <= ONE_C;
      end else if (bit_wr_s) begin
        count_r <= count_r + ONE_C;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en_r, par_odd_r, rx_par_r, chk_err_s;

  // Parity configuration and received parity bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
      rx_par_r  <= 1'b0;
    end else begin
      if (start_s) begin
        par_en_r  <= parity_en;
        par_odd_r <= parity_odd;
      end
      if (par_wr_s) rx_par_r <= sampled_bit;
    end
  end

  uart_rx_parity_chk #(.MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)) u_par_chk (
    .data       (shreg_r),
    .len        (len_r),
    .rx_parity  (rx_par_r),
    .parity_odd (par_odd_r),
    .par_err    (chk_err_s)
  );

  assign cfg_par_en_s = parity_en;
  assign lat_par_en_s = par_en_r;
  assign par_err_s    = par_en_r & chk_err_s;
`else
  logic unused_par_s;
  assign unused_par_s = parity_en ^ parity_odd ^ par_wr_s;
  assign cfg_par_en_s = 1'b0;
  assign lat_par_en_s = 1'b0;
  assign par_err_s    = 1'b0;
`endif

  // Output word register with overrun detection and one-cycle flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= {MAX_WIDTH{1'b0}};
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= short_s;
      overrun   <= 1'b0;
      if (commit_s) begin
        if (!out_valid || out_ready) begin
          out_valid  <= 1'b1;
          out_data   <= shreg_r;
          parity_err <= par_err_s;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_r != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Self-checking bench: queue-based frame model compared every cycle, plus literal expectations.
module tb_uart_rx_frame_deserializer;

  localparam int MAXW = 9;
  localparam int CW   = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   data_len;
  logic            msb_first, parity_en, parity_odd;
  logic            enable, sampled_bit, success, abort, out_ready;
  logic            out_valid, parity_err, frame_err, overrun, busy;
  logic [MAXW-1:0] out_data;

  int n_checks = 0;
  int n_err    = 0;
  bit run_chk  = 1'b0;

  // Frame-level model state
  bit              m_busy, m_valid, m_perr, m_ferr, m_ovr;
  logic [MAXW-1:0] m_data;
  int              m_len;
  bit              m_msb, m_pen, m_podd;
  logic            q[$];

  uart_rx_frame_deserializer #(.MAX_WIDTH(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .data_len(data_len), .msb_first(msb_first),
    .parity_en(parity_en), .parity_odd(parity_odd), .enable(enable),
    .sampled_bit(sampled_bit), .success(success), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    m_data = '0; q.delete();
  endtask

  // Advance the model by one clock using the stimulus currently applied
  task automatic model_step();
    bit              commit;
    int              need;
    logic [MAXW-1:0] w;
    logic            p;
    commit = 0;
    m_ferr = 0;
    m_ovr  = 0;
    need   = m_len + (m_pen ? 1 : 0);
    if (abort) begin
      m_busy = 0;
    end else if (m_busy && success) begin
      if (q.size() >= need) commit = 1;
      else                  m_ferr = 1;
      m_busy = 0;
    end else if (enable) begin
      if (!m_busy) begin
        m_len  = int'(data_len);
        m_msb  = msb_first;
        m_pen  = PAR_BUILT && parity_en;
        m_podd = parity_odd;
        q = {sampled_bit};
        m_busy = 1;
      end else if (q.size() < need) begin
        q.push_back(sampled_bit);
      end
    end
    if (commit) begin
      w = '0;
      p = m_podd;
      for (int i = 0; i < m_len; i++) begin
        w[m_msb ? (m_len - 1 - i) : i] = q[i];
        p = p ^ q[i];
      end
      if (m_pen) p = p ^ q[m_len];
      else       p = 1'b0;
      if (!m_valid || out_ready) begin
        m_valid = 1; m_data = w; m_perr = p;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic e, input logic b, input logic s, input logic a, input logic r);
    enable = e; sampled_bit = b; success = s; abort = a; out_ready = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [15:0] seq, input int n, input int len,
                      input logic msb, input logic pen, input logic podd);
    data_len = CW'(len); msb_first = msb; parity_en = pen; parity_odd = podd;
    for (int i = 0; i < n; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [15:0] seq, input int n, input int len,
                       input logic msb, input logic pen, input logic podd, input logic rdy);
    send(seq, n, len, msb, pen, podd);
    step(1'b0, 1'b0, 1'b1, 1'b0, rdy);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run_chk && rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("parity_err", parity_err, m_perr);
      end
    end
  end

  initial begin
    rst = 1'b0; data_len = 4'd8; msb_first = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    enable = 1'b0; sampled_bit = 1'b0; success = 1'b0; abort = 1'b0; out_ready = 1'b0;
    m_len = 8; m_msb = 0; m_pen = 0; m_podd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 9'h000);
    chk("rst_flags", {parity_err, frame_err, overrun, busy}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    run_chk = 1'b1;
    @(posedge clk);
    #1;

    frame(16'h0065, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("8n1_valid", out_valid, 1'b1);
    chk("8n1_data", out_data, 9'h065);
    chk("8n1_perr", parity_err, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("8n1_consumed", out_valid, 1'b0);

    frame(16'h0041, 7, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("msb7_data", out_data, 9'h041);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(16'h0003, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("msb8_data", out_data, 9'h0C0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    frame(16'h0101, 9, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("par_good_data", out_data, 9'h001);
    chk("par_good_perr", parity_err, 1'b0);
    frame(16'h0001, 9, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("par_bad_data", out_data, 9'h001);
    chk("par_bad_perr", parity_err, PAR_BUILT ? 1'b1 : 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(16'h0001, 9, 8, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    frame(16'h0015, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("short_ferr", frame_err, 1'b1);
    chk("short_valid", out_valid, 1'b0);
    chk("short_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 3, 8, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("abort_flags", {frame_err, overrun, out_valid, busy}, 4'b0000);
    send(16'h00FF, 8, 8, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_wins", {frame_err, out_valid, busy}, 3'b000);

    frame(16'h0011, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(16'h0022, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_keep", out_data, 9'h011);
    frame(16'h0022, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ready_load", out_data, 9'h022);
    chk("ready_noovr", overrun, 1'b0);

    send(16'h0007, 3, 8, 1'b0, 1'b0, 1'b0);
    enable = 1'b1; sampled_bit = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 9'h000);
    chk("arst_flags", {parity_err, frame_err, overrun, busy}, 4'b0000);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    frame(16'h00A5, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_rst_data", out_data, 9'h0A5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_deserializer.md
# uart_rx_frame_deserializer

Parametrised UART receive deserializer sitting between the oversampling bit-recovery stage and the RX FIFO/register interface. It assembles runtime-configurable frames of 5..MAX_WIDTH data bits, LSB- or MSB-first. It checks an optional parity bit and detects short and aborted frames. It presents each completed word on a valid/ready output port with overrun detection.

## Interface
- MAX_WIDTH, default 9, maximum data bits per frame; legal range 5..16.
- CNT_W, default 4, bit-counter width; must satisfy 2^CNT_W > MAX_WIDTH.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_len  input  CNT_W  data bits per frame, 5..MAX_WIDTH; sampled at first bit of each frame.
- msb_first  input  1  0 = LSB first; 1 = MSB first; sampled with data_len.
- parity_en  input  1  frame carries a parity bit after data; sampled with data_len.
- parity_odd  input  1  0 = even parity, 1 = odd parity; sampled with data_len.
- enable  input  1  one-cycle strobe: sampled_bit holds a valid recovered bit.
- sampled_bit  input  1  recovered serial bit.
- success  input  1  one-cycle strobe from the frame FSM: valid stop bit seen, commit frame.
- abort  input  1  discard the current frame; has priority over enable and success.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  MAX_WIDTH  received word, right-aligned; bits above data_len are zero.
- parity_err  output  1  parity flag of the word in out_data; qualified by out_valid.
- frame_err  output  1  one-cycle pulse: success arrived before all bits were collected.
- overrun  output  1  one-cycle pulse: a word was dropped because out_valid=1 and out_ready=0.
- busy  output  1  a frame is in progress; high in any state except S_IDLE.

## Operation
- FSM states: S_IDLE, S_DATA, S_PAR, S_WAIT.
- S_IDLE + enable:
  - latch data_len, msb_first, parity_en, parity_odd;
  - clear the shift register;
  - store the bit;
  - set count=1;
  - go to S_DATA. If the latched data_len is 1, go directly to S_PAR or S_WAIT instead; this is illegal configuration, but behaviour must be defined.
- Bit placement: index = count for LSB first; index = len-1-count for MSB first. This is a direct indexed write; no shifting.
- S_DATA + enable:
  - store the bit and increment count;
  - when count reaches len: go to S_PAR if the latched parity_en=1, else go to S_WAIT.
- S_PAR + enable: store the received parity bit; go to S_WAIT.
- S_WAIT + enable: the extra bit is ignored; stay in S_WAIT.
- success in S_WAIT commits the frame:
  - parity_err = XOR(data bits) XOR rx_parity XOR parity_odd;
  - parity_err is forced to 0 when parity is disabled.
  - Return to S_IDLE.
- success in S_DATA or S_PAR: pulse frame_err; discard the frame; return to S_IDLE.
- success in S_IDLE: ignored.
- abort in any state: return to S_IDLE; no output and no flags. Simultaneous abort+success: abort wins.
- Output port on commit:
  - If out_valid=0, or out_ready=1 in the same cycle: load out_data and parity_err; set out_valid=1.
  - Otherwise: drop the word, keep the old data, pulse overrun.
- No commit while out_valid=1 and out_ready=1: clear out_valid.
- out_data and parity_err change only on load.

## Timing
- Reset values: every output 0; state S_IDLE; count 0; shift register 0.
- Reset mid-frame clears the frame immediately, asynchronously; no flag is raised.
- Latency: success at edge N makes out_valid/out_data visible after edge N; frame_err and overrun pulse in the same cycle.
- Back-to-back frames: enable on the cycle after a commit starts a new frame without loss.
- enable coincident with success in S_WAIT: commit, and the bit is ignored.
- enable coincident with success in S_IDLE: the bit starts a frame.
- Throughput: one bit per cycle maximum.

## Configuration
- Macro UART_RX_PARITY_EN.
- Defined: S_PAR state, parity latch and checker are present; parity_en and parity_odd are honoured.
- Undefined: S_PAR and the checker are not built; parity_en and parity_odd are ignored; parity_err is tied to 0. After len data bits the FSM goes straight to S_WAIT.

## Structure
- Shared package uart_pkg: state enum type, MAX_WIDTH default, minimum data length constant (5).
- One sub-module uart_rx_parity_chk: combinational XOR reduction over data masked to len, plus rx_parity and parity_odd; instantiated only under UART_RX_PARITY_EN.
- Bit counter, indexed shift register, FSM and output register stay in the top module.

## Test plan
- 8N1, LSB first, bits 1,0,1,0,0,1,1,0 then success -> out_data=0x65, out_valid=1, parity_err=0; out_ready=1 next cycle -> out_valid=0.
- 7 bits, MSB first, bits 1,0,0,0,0,0,1 then success -> out_data=0x041, upper bits zero.
- 8E1 parity: data 0x01 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1. Macro undefined -> parity_err=0 always and the 9th bit is ignored.
- Short frame: 5 of 8 bits then success -> frame_err pulse, out_valid stays 0, busy=0 next cycle. abort after 3 bits -> no flags.
- Overrun: two frames 0x11 then 0x22 committed with out_ready=0 -> overrun pulse on second commit, out_data stays 0x11. Repeat with out_ready=1 on the second commit -> out_data=0x22 and no overrun.
- Assert rst low during bit 4 -> all outputs 0 immediately; a following full 0xA5 frame is received correctly.
